// File: rtl/decode_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the RV32I decode stage:
//   - major opcode constants
//   - ALU operation, branch type and writeback-select encodings
//   - memory access size encodings (equal to the load/store funct3)
//   - operand-select encodings
//   - the ID/EX register layout (idex_t)
//   - ALU operation lookup from funct3/funct7
// ---------------------------------------------------------------------------
package decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_LT   = 3'd3,
        BR_GE   = 3'd4,
        BR_LTU  = 3'd5,
        BR_GEU  = 3'd6,
        BR_JUMP = 3'd7
    } br_type_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_e;

    localparam logic [2:0] MEM_SIZE_B  = 3'b000;
    localparam logic [2:0] MEM_SIZE_H  = 3'b001;
    localparam logic [2:0] MEM_SIZE_W  = 3'b010;
    localparam logic [2:0] MEM_SIZE_BU = 3'b100;
    localparam logic [2:0] MEM_SIZE_HU = 3'b101;

    localparam logic OP_A_RS1 = 1'b0;
    localparam logic OP_A_PC  = 1'b1;
    localparam logic OP_B_RS2 = 1'b0;
    localparam logic OP_B_IMM = 1'b1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        alu_op_e     alu_op;
        logic        op_a_sel;
        logic        op_b_sel;
        br_type_e    br_type;
        logic        mem_rden;
        logic        mem_wren;
        logic [2:0]  mem_size;
        wb_sel_e     wb_sel;
        logic        rd_wren;
        logic        illegal;
    } idex_t;

    // funct7[5] (instr[30]) selects SUB only for register-register ops;
    // for shifts it selects arithmetic right shift in both forms.
    function automatic alu_op_e alu_from_funct(input logic [2:0] funct3,
                                               input logic       alt,
                                               input logic       is_reg);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile
// 32 x 32-bit integer register file, two combinational read ports and one
// write port. x0 always reads zero and is never written. Synchronous
// active-low reset clears every register; no write happens during reset.
//
// Build option:
//   DECODE_WB_BYPASS_EN  - when defined, a read of the register being written
//                          in the same cycle returns the write data
//                          (write-first). When undefined, reads return only
//                          stored values.
//
// Ports:
//   clk_i, rst_ni     clock, synchronous active-low reset
//   raddr_a, rdata_a  read port A
//   raddr_b, rdata_b  read port B
//   waddr, wdata, wren write port
// ---------------------------------------------------------------------------
module regfile (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  raddr_a,
    output logic [31:0] rdata_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_b,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        wren
);

    logic [31:0] regs [32];
    logic        write_ok;

    assign write_ok = wren && rst_ni && (waddr != 5'd0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a = (raddr_a == 5'd0) ? '0 : regs[raddr_a];
        rdata_b = (raddr_b == 5'd0) ? '0 : regs[raddr_b];
`ifdef DECODE_WB_BYPASS_EN
        if (write_ok && (waddr == raddr_a)) rdata_a = wdata;
        if (write_ok && (waddr == raddr_b)) rdata_b = wdata;
`endif
    end

endmodule

// File: rtl/decode_cycle.sv
// ---------------------------------------------------------------------------
// decode_cycle
// RV32I decode stage: instruction decode, immediate generation, register
// file read, load-use hazard detection and the ID/EX pipeline register.
//
// Build option:
//   DECODE_WB_BYPASS_EN  - passed through to regfile (write-first reads).
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   instr_D, pc_D            instruction and its PC from fetch
//   is_taken_E               redirect from execute, flushes decode
//   rd_W, wb_data_W,
//   rd_wren_W                writeback port into the register file
//   stall                    load-use hold request to fetch (combinational)
//   *_E                      ID/EX register contents
// ---------------------------------------------------------------------------
module decode_cycle
    import decode_pkg::*;
#(
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] instr_D,
    input  logic [31:0] pc_D,
    input  logic        is_taken_E,
    input  logic [4:0]  rd_W,
    input  logic [31:0] wb_data_W,
    input  logic        rd_wren_W,
    output logic        stall,
    output logic [31:0] pc_E,
    output logic [31:0] rs1_data_E,
    output logic [31:0] rs2_data_E,
    output logic [31:0] imm_E,
    output logic [4:0]  rs1_E,
    output logic [4:0]  rs2_E,
    output logic [4:0]  rd_E,
    output logic [3:0]  alu_op_E,
    output logic        op_a_sel_E,
    output logic        op_b_sel_E,
    output logic [2:0]  br_type_E,
    output logic        mem_rden_E,
    output logic        mem_wren_E,
    output logic [2:0]  mem_size_E,
    output logic [1:0]  wb_sel_E,
    output logic        rd_wren_E,
    output logic        illegal_E
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        known;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        hazard;
    idex_t       dec_p0;
    idex_t       idex_p1;

    assign opcode = instr_D[6:0];
    assign funct3 = instr_D[14:12];
    assign rs1    = instr_D[19:15];
    assign rs2    = instr_D[24:20];
    assign rd     = instr_D[11:7];

    assign imm_i = {{20{instr_D[31]}}, instr_D[31:20]};
    assign imm_s = {{20{instr_D[31]}}, instr_D[31:25], instr_D[11:7]};
    assign imm_b = {{19{instr_D[31]}}, instr_D[31], instr_D[7],
                    instr_D[30:25], instr_D[11:8], 1'b0};
    assign imm_u = {instr_D[31:12], 12'b0};
    assign imm_j = {{11{instr_D[31]}}, instr_D[31], instr_D[19:12],
                    instr_D[20], instr_D[30:21], 1'b0};

    regfile u_regfile (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .raddr_a (rs1),
        .rdata_a (rs1_data),
        .raddr_b (rs2),
        .rdata_b (rs2_data),
        .waddr   (rd_W),
        .wdata   (wb_data_W),
        .wren    (rd_wren_W)
    );

    // ---- stage D: combinational decode ----
    always_comb begin
        dec_p0   = '0;
        known    = 1'b1;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec_p0.imm      = imm_u;
                dec_p0.op_b_sel = OP_B_IMM;
                dec_p0.wb_sel   = WB_IMM;
                dec_p0.rd_wren  = 1'b1;
            end
            OPC_AUIPC: begin
                dec_p0.imm      = imm_u;
                dec_p0.op_a_sel = OP_A_PC;
                dec_p0.op_b_sel = OP_B_IMM;
                dec_p0.rd_wren  = 1'b1;
            end
            OPC_JAL: begin
                dec_p0.imm      = imm_j;
                dec_p0.op_a_sel = OP_A_PC;
                dec_p0.op_b_sel = OP_B_IMM;
                dec_p0.br_type  = BR_JUMP;
                dec_p0.wb_sel   = WB_PC4;
                dec_p0.rd_wren  = 1'b1;
            end
            OPC_JALR: begin
                uses_rs1        = 1'b1;
                dec_p0.imm      = imm_i;
                dec_p0.op_b_sel = OP_B_IMM;
                dec_p0.br_type  = BR_JUMP;
                dec_p0.wb_sel   = WB_PC4;
                dec_p0.rd_wren  = 1'b1;
            end
            OPC_BRANCH: begin
                uses_rs1        = 1'b1;
                uses_rs2        = 1'b1;
                dec_p0.imm      = imm_b;
                // ALU forms the target; the comparator uses rs1/rs2 data.
                dec_p0.op_a_sel = OP_A_PC;
                dec_p0.op_b_sel = OP_B_IMM;
                case (funct3)
                    3'b000:  dec_p0.br_type = BR_EQ;
                    3'b001:  dec_p0.br_type = BR_NE;
                    3'b100:  dec_p0.br_type = BR_LT;
                    3'b101:  dec_p0.br_type = BR_GE;
                    3'b110:  dec_p0.br_type = BR_LTU;
                    3'b111:  dec_p0.br_type = BR_GEU;
                    default: dec_p0.br_type = BR_NONE;
                endcase
            end
            OPC_LOAD: begin
                uses_rs1        = 1'b1;
                dec_p0.imm      = imm_i;
                dec_p0.op_b_sel = OP_B_IMM;
                dec_p0.mem_rden = 1'b1;
                dec_p0.mem_size = funct3;
                dec_p0.wb_sel   = WB_MEM;
                dec_p0.rd_wren  = 1'b1;
            end
            OPC_STORE: begin
                uses_rs1        = 1'b1;
                uses_rs2        = 1'b1;
                dec_p0.imm      = imm_s;
                dec_p0.op_b_sel = OP_B_IMM;
                dec_p0.mem_wren = 1'b1;
                dec_p0.mem_size = funct3;
            end
            OPC_OP_IMM: begin
                uses_rs1        = 1'b1;
                dec_p0.imm      = imm_i;
                dec_p0.op_b_sel = OP_B_IMM;
                dec_p0.alu_op   = alu_from_funct(funct3, instr_D[30], 1'b0);
                dec_p0.rd_wren  = 1'b1;
            end
            OPC_OP: begin
                uses_rs1        = 1'b1;
                uses_rs2        = 1'b1;
                dec_p0.alu_op   = alu_from_funct(funct3, instr_D[30], 1'b1);
                dec_p0.rd_wren  = 1'b1;
            end
            default: known = 1'b0;
        endcase

        // Register indices are only reported when actually used, so that
        // later forwarding logic never matches a don't-care field.
        dec_p0.pc       = pc_D;
        dec_p0.rs1_data = rs1_data;
        dec_p0.rs2_data = rs2_data;
        dec_p0.rs1      = uses_rs1 ? rs1 : 5'd0;
        dec_p0.rs2      = uses_rs2 ? rs2 : 5'd0;
        dec_p0.rd       = dec_p0.rd_wren ? rd : 5'd0;

        // A bubble or unknown opcode becomes an all-zero slot; only an
        // unknown opcode that is not the bubble word flags illegal.
        if (!known || (instr_D == BUBBLE_INSTR)) begin
            dec_p0         = '0;
            uses_rs1       = 1'b0;
            uses_rs2       = 1'b0;
            dec_p0.illegal = (instr_D != BUBBLE_INSTR);
        end
    end

    // Load in E whose result is needed by the instruction in D. A redirect
    // discards D anyway, so it suppresses the hold.
    assign hazard = idex_p1.mem_rden && (idex_p1.rd != 5'd0) &&
                    ((uses_rs1 && (rs1 == idex_p1.rd)) ||
                     (uses_rs2 && (rs2 == idex_p1.rd)));
    assign stall  = hazard && !is_taken_E && rst_ni;

    // ---- stage D -> E: ID/EX register ----
    always_ff @(posedge clk_i) begin
        if (!rst_ni || is_taken_E || stall) begin
            idex_p1 <= '0;
        end else begin
            idex_p1 <= dec_p0;
        end
    end

    assign pc_E       = idex_p1.pc;
    assign rs1_data_E = idex_p1.rs1_data;
    assign rs2_data_E = idex_p1.rs2_data;
    assign imm_E      = idex_p1.imm;
    assign rs1_E      = idex_p1.rs1;
    assign rs2_E      = idex_p1.rs2;
    assign rd_E       = idex_p1.rd;
    assign alu_op_E   = idex_p1.alu_op;
    assign op_a_sel_E = idex_p1.op_a_sel;
    assign op_b_sel_E = idex_p1.op_b_sel;
    assign br_type_E  = idex_p1.br_type;
    assign mem_rden_E = idex_p1.mem_rden;
    assign mem_wren_E = idex_p1.mem_wren;
    assign mem_size_E = idex_p1.mem_size;
    assign wb_sel_E   = idex_p1.wb_sel;
    assign rd_wren_E  = idex_p1.rd_wren;
    assign illegal_E  = idex_p1.illegal;

endmodule

// File: tb/tb_decode_cycle.sv
// ---------------------------------------------------------------------------
// tb_decode_cycle
// Directed bench for decode_cycle. Inputs change 1 time unit after the
// rising edge; registered outputs and the combinational stall are sampled
// in that same window.
// ---------------------------------------------------------------------------
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic        is_taken_E;
    logic [4:0]  rd_W;
    logic [31:0] wb_data_W;
    logic        rd_wren_W;
    logic        stall;
    logic [31:0] pc_E;
    logic [31:0] rs1_data_E;
    logic [31:0] rs2_data_E;
    logic [31:0] imm_E;
    logic [4:0]  rs1_E;
    logic [4:0]  rs2_E;
    logic [4:0]  rd_E;
    logic [3:0]  alu_op_E;
    logic        op_a_sel_E;
    logic        op_b_sel_E;
    logic [2:0]  br_type_E;
    logic        mem_rden_E;
    logic        mem_wren_E;
    logic [2:0]  mem_size_E;
    logic [1:0]  wb_sel_E;
    logic        rd_wren_E;
    logic        illegal_E;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ADDI_X1_X0_5 = 32'h0050_0093;
    localparam logic [31:0] I_LW_X2_0_X1   = 32'h0000_A103;
    localparam logic [31:0] I_ADD_X3_X2_X1 = 32'h0011_01B3;
    localparam logic [31:0] I_ADDI_X6_X5_0 = 32'h0002_8313;
    localparam logic [31:0] I_ADDI_X6_X4_0 = 32'h0002_0313;
    localparam logic [31:0] I_ADDI_X6_X1_0 = 32'h0000_8313;
    localparam logic [31:0] I_SW_X2_8_X1   = 32'h0020_A423;
    localparam logic [31:0] I_BEQ_M8       = 32'hFE20_8CE3;
    localparam logic [31:0] I_LUI_X7       = 32'h1234_53B7;
    localparam logic [31:0] I_JAL_X1_16    = 32'h0100_00EF;

    decode_cycle dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .instr_D    (instr_D),
        .pc_D       (pc_D),
        .is_taken_E (is_taken_E),
        .rd_W       (rd_W),
        .wb_data_W  (wb_data_W),
        .rd_wren_W  (rd_wren_W),
        .stall      (stall),
        .pc_E       (pc_E),
        .rs1_data_E (rs1_data_E),
        .rs2_data_E (rs2_data_E),
        .imm_E      (imm_E),
        .rs1_E      (rs1_E),
        .rs2_E      (rs2_E),
        .rd_E       (rd_E),
        .alu_op_E   (alu_op_E),
        .op_a_sel_E (op_a_sel_E),
        .op_b_sel_E (op_b_sel_E),
        .br_type_E  (br_type_E),
        .mem_rden_E (mem_rden_E),
        .mem_wren_E (mem_wren_E),
        .mem_size_E (mem_size_E),
        .wb_sel_E   (wb_sel_E),
        .rd_wren_E  (rd_wren_E),
        .illegal_E  (illegal_E)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_ni     = 1'b0;
        instr_D    = 32'h0;
        pc_D       = 32'h0;
        is_taken_E = 1'b0;
        // A write attempted during reset must be ignored.
        rd_W       = 5'd4;
        wb_data_W  = 32'hA5A5_A5A5;
        rd_wren_W  = 1'b1;
        repeat (3) step();

        chk("rst_pc_E",      pc_E,             32'h0);
        chk("rst_rd_E",      32'(rd_E),        32'h0);
        chk("rst_imm_E",     imm_E,            32'h0);
        chk("rst_rd_wren_E", 32'(rd_wren_E),   32'h0);
        chk("rst_illegal_E", 32'(illegal_E),   32'h0);
        chk("rst_stall",     32'(stall),       32'h0);

        // addi x1,x0,5 while writing x1=0x10 through W
        rst_ni    = 1'b1;
        instr_D   = I_ADDI_X1_X0_5;
        pc_D      = 32'h100;
        rd_W      = 5'd1;
        wb_data_W = 32'h10;
        rd_wren_W = 1'b1;
        step();
        rd_wren_W = 1'b0;
        chk("addi_rd_E",      32'(rd_E),       32'd1);
        chk("addi_imm_E",     imm_E,           32'd5);
        chk("addi_rd_wren_E", 32'(rd_wren_E),  32'd1);
        chk("addi_alu_op_E",  32'(alu_op_E),   32'd0);
        chk("addi_op_b_sel",  32'(op_b_sel_E), 32'd1);
        chk("addi_pc_E",      pc_E,            32'h100);
        chk("addi_rs1_data",  rs1_data_E,      32'h0);

        // lw x2,0(x1) then dependent add x3,x2,x1
        instr_D = I_LW_X2_0_X1;
        pc_D    = 32'h104;
        step();
        chk("lw_mem_rden_E", 32'(mem_rden_E), 32'd1);
        chk("lw_rd_E",       32'(rd_E),       32'd2);
        chk("lw_rs1_data_E", rs1_data_E,      32'h10);
        chk("lw_wb_sel_E",   32'(wb_sel_E),   32'd1);
        chk("lw_mem_size_E", 32'(mem_size_E), 32'd2);

        instr_D = I_ADD_X3_X2_X1;
        pc_D    = 32'h108;
        #1;
        chk("lu_stall_on", 32'(stall), 32'd1);
        step();
        chk("lu_bub_rd_E",    32'(rd_E),       32'd0);
        chk("lu_bub_rd_wren", 32'(rd_wren_E),  32'd0);
        chk("lu_bub_pc_E",    pc_E,            32'd0);
        chk("lu_bub_mem_rden",32'(mem_rden_E), 32'd0);
        chk("lu_stall_off",   32'(stall),      32'd0);
        step();
        chk("add_rd_E",      32'(rd_E),       32'd3);
        chk("add_rs1_E",     32'(rs1_E),      32'd2);
        chk("add_rs2_E",     32'(rs2_E),      32'd1);
        chk("add_pc_E",      pc_E,            32'h108);
        chk("add_rd_wren_E", 32'(rd_wren_E),  32'd1);
        chk("add_op_b_sel",  32'(op_b_sel_E), 32'd0);
        chk("add_rs2_data",  rs2_data_E,      32'h10);

        // flush in the same cycle as a load-use hazard
        instr_D = I_LW_X2_0_X1;
        pc_D    = 32'h10C;
        step();
        instr_D    = I_ADD_X3_X2_X1;
        pc_D       = 32'h110;
        is_taken_E = 1'b1;
        #1;
        chk("fl_stall", 32'(stall), 32'd0);
        step();
        is_taken_E = 1'b0;
        chk("fl_rd_wren_E",  32'(rd_wren_E),  32'd0);
        chk("fl_mem_wren_E", 32'(mem_wren_E), 32'd0);
        chk("fl_rd_E",       32'(rd_E),       32'd0);
        chk("fl_pc_E",       pc_E,            32'd0);

        // write x5 while reading it
        instr_D   = I_ADDI_X6_X5_0;
        pc_D      = 32'h114;
        rd_W      = 5'd5;
        wb_data_W = 32'hDEAD_BEEF;
        rd_wren_W = 1'b1;
        step();
        rd_wren_W = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
        chk("wb_same_cycle", rs1_data_E, 32'hDEAD_BEEF);
`else
        chk("wb_same_cycle", rs1_data_E, 32'h0);
`endif
        step();
        chk("wb_next_cycle", rs1_data_E, 32'hDEAD_BEEF);

        // write to x0 is discarded
        instr_D   = I_ADDI_X1_X0_5;
        rd_W      = 5'd0;
        wb_data_W = 32'hFFFF_FFFF;
        rd_wren_W = 1'b1;
        step();
        rd_wren_W = 1'b0;
        chk("x0_same_cycle", rs1_data_E, 32'h0);
        step();
        chk("x0_later", rs1_data_E, 32'h0);

        // x4 write during reset had no effect
        instr_D = I_ADDI_X6_X4_0;
        step();
        chk("rst_no_write", rs1_data_E, 32'h0);

        // illegal and bubble words
        instr_D = 32'hFFFF_FFFF;
        step();
        chk("ill_illegal_E",  32'(illegal_E),  32'd1);
        chk("ill_rd_wren_E",  32'(rd_wren_E),  32'd0);
        chk("ill_mem_rden_E", 32'(mem_rden_E), 32'd0);
        chk("ill_mem_wren_E", 32'(mem_wren_E), 32'd0);
        chk("ill_br_type_E",  32'(br_type_E),  32'd0);
        instr_D = 32'h0;
        step();
        chk("bub_illegal_E", 32'(illegal_E), 32'd0);
        chk("bub_rd_wren_E", 32'(rd_wren_E), 32'd0);

        // store, branch, lui, jal
        instr_D = I_SW_X2_8_X1;
        pc_D    = 32'h200;
        step();
        chk("sw_mem_wren_E", 32'(mem_wren_E), 32'd1);
        chk("sw_imm_E",      imm_E,           32'd8);
        chk("sw_rd_wren_E",  32'(rd_wren_E),  32'd0);
        chk("sw_rs2_E",      32'(rs2_E),      32'd2);
        instr_D = I_BEQ_M8;
        step();
        chk("beq_imm_E",     imm_E,           32'hFFFF_FFF8);
        chk("beq_br_type_E", 32'(br_type_E),  32'd1);
        chk("beq_op_a_sel",  32'(op_a_sel_E), 32'd1);
        chk("beq_rd_wren_E", 32'(rd_wren_E),  32'd0);
        instr_D = I_LUI_X7;
        step();
        chk("lui_imm_E",    imm_E,         32'h1234_5000);
        chk("lui_wb_sel_E", 32'(wb_sel_E), 32'd3);
        chk("lui_rd_E",     32'(rd_E),     32'd7);
        instr_D = I_JAL_X1_16;
        step();
        chk("jal_imm_E",     imm_E,          32'd16);
        chk("jal_br_type_E", 32'(br_type_E), 32'd7);
        chk("jal_wb_sel_E",  32'(wb_sel_E),  32'd2);

        // reset in the middle of a stall
        instr_D = I_LW_X2_0_X1;
        step();
        instr_D = I_ADD_X3_X2_X1;
        #1;
        chk("rs_stall_before", 32'(stall), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("rs_stall_in_rst", 32'(stall), 32'd0);
        step();
        rst_ni = 1'b1;
        #1;
        chk("rs_stall_after", 32'(stall), 32'd0);
        chk("rs_rd_E",        32'(rd_E),  32'd0);

        // registers cleared by reset (x1 held 0x10)
        instr_D = I_ADDI_X6_X1_0;
        step();
        chk("rs_x1_cleared", rs1_data_E, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_cycle.md
DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
REQ-001 SHALL have parameter BUBBLE_INSTR, default 32'h0000_0000, the instruction word treated as a pipeline bubble.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_ni, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have port instr_D, input, 32, the instruction word from the fetch stage register.
REQ-005 SHALL have port pc_D, input, 32, the PC of instr_D.
REQ-006 SHALL have port is_taken_E, input, 1, the branch/jump redirect from execute; flushes decode.
REQ-007 SHALL have ports rd_W (input, 5), wb_data_W (input, 32) and rd_wren_W (input, 1), the writeback port.
REQ-008 SHALL have port stall, output, 1, the load-use hold request to fetch.
REQ-009 SHALL have outputs pc_E[32], rs1_data_E[32], rs2_data_E[32], imm_E[32], rs1_E[5], rs2_E[5] and rd_E[5], the ID/EX register.
REQ-010 SHALL have outputs alu_op_E[4], op_a_sel_E[1], op_b_sel_E[1], br_type_E[3], mem_rden_E[1], mem_wren_E[1], mem_size_E[3], wb_sel_E[2], rd_wren_E[1] and illegal_E[1].

Function
REQ-011 SHALL decode RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP into control fields in the same cycle instr_D is presented.
REQ-012 SHALL form the I/S/B/U/J immediates sign-extended to 32 bits; B and J immediates SHALL have bit 0 forced to 0.
REQ-013 SHALL treat BUBBLE_INSTR and any unrecognised opcode as a bubble: all write, mem and branch enables 0; illegal_E=1 only for an unrecognised opcode other than BUBBLE_INSTR.
REQ-014 SHALL contain a 32x32 register file: two combinational reads and one write per cycle when rd_wren_W=1 and rd_W!=0; x0 SHALL always read 0.
REQ-015 SHALL load the ID/EX register every cycle unless it is flushed or has a bubble injected; latency from instr_D to the *_E outputs is 1 cycle.
REQ-016 SHALL assert stall combinationally when mem_rden_E=1, rd_E!=0, and rd_E equals a source register actually used by instr_D (rs1 for all except LUI/AUIPC/JAL; rs2 for OP/STORE/BRANCH).
REQ-017 SHALL inject a bubble into ID/EX on the clock edge where stall=1; a stall SHALL last exactly 1 cycle for one dependent load.
REQ-018 SHALL inject a bubble into ID/EX and force stall=0 when is_taken_E=1; a flush SHALL take priority over a stall in the same cycle.
REQ-019 SHALL clear every field of a bubble to 0, pc_E included.

Reset
REQ-020 SHALL, on a clock edge with rst_ni=0, clear all ID/EX outputs to 0, clear all 32 registers to 0, and hold stall at 0.
REQ-021 SHALL perform no register-file write while rst_ni=0, regardless of rd_wren_W.
REQ-022 SHALL, when reset is asserted in the middle of a stall, leave no stall pending after reset.

Configuration
REQ-023 SHALL, when DECODE_WB_BYPASS_EN is defined, return wb_data_W on a read when rd_wren_W=1, rd_W!=0 and rd_W equals the read address (write-first).
REQ-024 SHALL, when DECODE_WB_BYPASS_EN is not defined, return only stored values; a write becomes visible on the cycle after it.

Structure
REQ-025 SHALL take from the shared package decode_pkg: the opcode constants, alu_op_e (4b), br_type_e (3b), wb_sel_e (2b: ALU, MEM, PC4, IMM) and the mem_size encodings (funct3).
REQ-026 SHALL implement the register file as sub-module regfile (clk_i, rst_ni, 2 read ports, 1 write port, macro-controlled bypass).
REQ-027 SHALL keep decode logic, hazard detection and the ID/EX register in decode_cycle.

Verification
REQ-028 SHALL cover: after reset, instr_D=32'h00500093 (addi x1,x0,5) -> next cycle rd_E=1, imm_E=5, rd_wren_E=1, alu_op_E=ADD, op_b_sel_E=imm.
REQ-029 SHALL cover: lw x2,0(x1) in E, then add x3,x2,x1 in D -> stall=1 for 1 cycle, ID/EX holds a bubble, and add reaches E on the following cycle.
REQ-030 SHALL cover: is_taken_E=1 in the same cycle as a load-use hazard -> stall=0 and ID/EX is a bubble (rd_wren_E=0, mem_wren_E=0).
REQ-031 SHALL cover: write x5=32'hDEADBEEF on the W port while instr_D reads x5 -> rs1_data_E=32'hDEADBEEF with the macro defined, the old value without it.
REQ-032 SHALL cover: a write to x0 with data 32'hFFFFFFFF -> later reads of x0 return 0.
REQ-033 SHALL cover: instr_D=32'hFFFFFFFF -> illegal_E=1 and all enables 0; instr_D=32'h0 -> illegal_E=0 (bubble).
